fetch_stage: RTL

Instruction-fetch stage of the RISC-V core. Owns the program counter and drives the byte address into the combinational 128-word instruction memory. Captures the returned instruction into the IF/ID pipeline register for the decoder. Handles stall, branch/jump redirect with flush, a one-cycle boot after reset, and a halt on fetch fault.

---
 rtl/rv_pkg.sv | 18 +
 rtl/fetch_stage_if.sv | 20 ++
 rtl/fetch_stage_if_id_reg.sv | 37 +++
 rtl/fetch_stage.sv | 89 ++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RISC-V core definitions: datapath width, bubble encoding, fetch FSM states.
// The fetch stage reads these through the rv_pkg:: scope.
package rv_pkg;

    localparam int XLEN = 32;

    // addi x0,x0,0 is the canonical bubble
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    localparam logic [XLEN-1:0] PC_INC = XLEN'(4);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory bus between the fetch stage (master) and the combinational IMEM (slave).
// The memory answers imem_inst in the same cycle that imem_addr is presented.
interface fetch_stage_if #(
    parameter int XLEN = rv_pkg::XLEN
);

    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_inst;

    modport master (
        output imem_addr,
        input  imem_inst
    );

    modport slave (
        input  imem_addr,
        output imem_inst
    );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: captures pc, pc+4 and instruction on load,
// drops to a NOP bubble on flush, and otherwise holds.
module if_id_reg #(
    parameter int          XLEN     = rv_pkg::XLEN,
    parameter logic [31:0] NOP_INST = rv_pkg::NOP_INST
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            flush,
    input  logic [XLEN-1:0] pc,
    input  logic [31:0]     inst,
    output logic            valid_q,
    output logic [XLEN-1:0] pc_q,
    output logic [XLEN-1:0] pc_plus4_q,
    output logic [31:0]     inst_q
);

    // Flush leaves pc/pc_plus4 untouched so a bubble still carries its last address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            pc_plus4_q <= '0;
            inst_q     <= NOP_INST;
        end else if (flush) begin
            valid_q <= 1'b0;
            inst_q  <= NOP_INST;
        end else if (load) begin
            valid_q    <= 1'b1;
            pc_q       <= pc;
            pc_plus4_q <= pc + XLEN'(rv_pkg::PC_INC);
            inst_q     <= inst;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the combinational IMEM and fills IF/ID.
// Handles stall, redirect with flush, a one-cycle boot after reset and a sticky halt on fault.
module fetch_stage #(
    parameter int              XLEN       = rv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              IMEM_WORDS = 128,
    parameter logic [31:0]     NOP_INST   = rv_pkg::NOP_INST
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_target,
    fetch_stage_if.master      imem,
    output logic               if_id_valid,
    output logic [XLEN-1:0]    if_id_pc,
    output logic [XLEN-1:0]    if_id_pc_plus4,
    output logic [31:0]        if_id_inst,
    output logic               fetch_fault
);

    localparam logic [XLEN-1:0] IMEM_LIMIT = XLEN'(IMEM_WORDS * 4);

    rv_pkg::fetch_state_e state;
    logic [XLEN-1:0]      pc_q;
    logic                 in_run;
    logic                 capture;
    logic                 fault_cond;
    logic                 ifid_load;
    logic                 ifid_flush;

    assign imem.imem_addr = pc_q;

    // Redirect outranks stall, and both outrank the fault check.
    assign in_run     = (state == rv_pkg::ST_RUN);
    assign capture    = in_run && !redirect_valid && !stall;
    assign fault_cond = (pc_q[1:0] != 2'b00) || (pc_q >= IMEM_LIMIT);
    assign ifid_load  = capture && !fault_cond;
    assign ifid_flush = (in_run && redirect_valid) || (capture && fault_cond);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= rv_pkg::ST_BOOT;
            pc_q        <= RESET_PC;
            fetch_fault <= 1'b0;
        end else begin
            case (state)
                rv_pkg::ST_BOOT: begin
                    state <= rv_pkg::ST_RUN;
                end
                rv_pkg::ST_RUN: begin
                    if (redirect_valid) begin
                        pc_q <= redirect_target;
                    end else if (!stall) begin
                        if (fault_cond) begin
                            fetch_fault <= 1'b1;
                            state       <= rv_pkg::ST_HALT;
                        end else begin
                            pc_q <= pc_q + XLEN'(rv_pkg::PC_INC);
                        end
                    end
                end
                rv_pkg::ST_HALT: begin
                    state <= rv_pkg::ST_HALT;
                end
                default: begin
                    state <= rv_pkg::ST_HALT;
                end
            endcase
        end
    end

    if_id_reg #(
        .XLEN     (XLEN),
        .NOP_INST (NOP_INST)
    ) u_if_id (
        .clk        (clk),
        .rst        (rst),
        .load       (ifid_load),
        .flush      (ifid_flush),
        .pc         (pc_q),
        .inst       (imem.imem_inst),
        .valid_q    (if_id_valid),
        .pc_q       (if_id_pc),
        .pc_plus4_q (if_id_pc_plus4),
        .inst_q     (if_id_inst)
    );

endmodule
